// File: rtl/ss_adc_pkg.sv
// Shared types, widths and the thermometer validity check
// for the flash ADC conversion sequencer.
`timescale 1ns/1ps
package ss_adc_pkg;

  localparam int THERM_W = 8;
  localparam int CODE_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    SETTLE,
    OUT
  } state_e;

  // Legal word: bit 0 clear and bits [7:1] a run of ones from bit 1.
  function automatic logic is_valid_therm(
    input logic [THERM_W-1:0] t
  );
    logic [THERM_W-2:0] x;
    logic [THERM_W-2:0] one;
    x   = t[THERM_W-1:1];
    one = {{(THERM_W-2){1'b0}}, 1'b1};
    return !t[0] && ((x & (x + one)) == '0);
  endfunction

endpackage

// File: rtl/ss_therm_popcount_encoder.sv
// Bubble-tolerant thermometer encoder: popcount of bits [7:1]
// plus a flag for words that are not clean thermometer codes.
`timescale 1ns/1ps
module ss_therm_popcount_encoder
  import ss_adc_pkg::*;
(
  input  logic [THERM_W-1:0] therm_i,
  output logic [CODE_W-1:0]  code_o,
  output logic               valid_o
);

  always_comb begin
    code_o = '0;
    for (int i = 1; i < THERM_W; i++) begin
      code_o = code_o + CODE_W'(therm_i[i]);
    end
    valid_o = is_valid_therm(therm_i);
  end

endmodule

// File: rtl/ss_flash_adc_sequencer.sv
// Track/hold sequencing, sample capture, averaging and
// valid/ready result delivery for the 3-bit flash ADC.
`timescale 1ns/1ps
module ss_flash_adc_sequencer
  import ss_adc_pkg::*;
#(
  parameter int TRACK_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int AVG_LOG2      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont_mode,
  input  logic [THERM_W-1:0] therm_in,
  output logic               sh_track,
  output logic [CODE_W-1:0]  data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               bubble_err,
  output logic               busy
);

  localparam int ACC_W  = CODE_W + AVG_LOG2;
  localparam int PH_MAX = (TRACK_CYCLES > SETTLE_CYCLES)
                        ? TRACK_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam int SMP_W  = AVG_LOG2 + 1;

  localparam logic [PH_W-1:0] TRK_LAST =
    PH_W'(TRACK_CYCLES - 1);
  localparam logic [PH_W-1:0] SET_LAST =
    PH_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_W-1:0] SMP_LAST =
    SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [ACC_W-1:0] RND =
    ACC_W'((1 << AVG_LOG2) >> 1);

  state_e            state_q;
  logic [PH_W-1:0]   ph_q;
  logic [SMP_W-1:0]  smp_q;
  logic [ACC_W-1:0]  acc_q;
  logic              bub_q;

  logic [CODE_W-1:0] code;
  logic              code_ok;
  logic [ACC_W-1:0]  acc_d;
  logic [ACC_W-1:0]  rnd_sum;
  logic [CODE_W-1:0] avg_d;
  logic              bub_d;

  ss_therm_popcount_encoder u_enc (
    .therm_i (therm_in),
    .code_o  (code),
    .valid_o (code_ok)
  );

  // Sum including the sample captured on this edge.
  assign acc_d   = acc_q + ACC_W'(code);
  assign rnd_sum = acc_d + RND;
  assign avg_d   = CODE_W'(rnd_sum >> AVG_LOG2);
  assign bub_d   = bub_q | ~code_ok;
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      smp_q      <= '0;
      acc_q      <= '0;
      bub_q      <= 1'b0;
      sh_track   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      bubble_err <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= TRACK;
            sh_track <= 1'b1;
            ph_q     <= '0;
            smp_q    <= '0;
            acc_q    <= '0;
            bub_q    <= 1'b0;
          end
        end
        TRACK: begin
          if (ph_q == TRK_LAST) begin
            state_q  <= SETTLE;
            sh_track <= 1'b0;
            ph_q     <= '0;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        SETTLE: begin
          if (ph_q == SET_LAST) begin
            acc_q <= acc_d;
            bub_q <= bub_d;
            ph_q  <= '0;
            if (smp_q == SMP_LAST) begin
              state_q    <= OUT;
              data_valid <= 1'b1;
              data_out   <= avg_d;
              bubble_err <= bub_d;
            end else begin
              state_q  <= TRACK;
              sh_track <= 1'b1;
              smp_q    <= smp_q + 1'b1;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        OUT: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            if (cont_mode) begin
              state_q  <= TRACK;
              sh_track <= 1'b1;
              ph_q     <= '0;
              smp_q    <= '0;
              acc_q    <= '0;
              bub_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
